ram_stream_out: RTL and testbench
=================================

# ram_stream_out

Read-side streaming engine for the dual-port result RAM in the Multi-MAC matrix-multiply path. On a start command it walks `num_words` consecutive RAM addresses from `base_addr`, with wrap-around, and presents the words on a valid/ready output stream with `m_tlast` on the final word. It can run while the MAC writer is still filling the RAM: it issues a read only for words the writer has already committed. It sustains one word per cycle under backpressure using a 2-entry output buffer.

## Interface
- `DATA_WIDTH`, 4096, width of one RAM word and stream beat.
- `DEPTH`, 64, number of RAM words. `AW = max(1, $clog2(DEPTH))`.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  command strobe; sampled only when `busy`=0.
- `base_addr`  in  AW  first RAM address; latched on accepted `start`.
- `num_words`  in  AW+1  words to stream, 0..DEPTH; latched on accepted `start`.
- `avail_count`  in  AW+1  words committed by the writer, counted from `base_addr`; monotonic during a job.
- `ram_rd_addr`  out  AW  drives the RAM read address.
- `ram_dout`  in  DATA_WIDTH  RAM read data; valid one cycle after the address is presented.
- `m_tdata`  out  DATA_WIDTH  stream data.
- `m_tvalid`  out  1  stream valid.
- `m_tlast`  out  1  high with the final beat of a job.
- `m_tready`  in  1  stream ready from the consumer.
- `busy`  out  1  job in progress.
- `done`  out  1  one-cycle pulse at the end of a job.

## Operation
- States:
  - IDLE: accepts `start`.
  - RUN: reads are still to be issued.
  - DRAIN: all reads are issued; waiting for the buffer to empty.
- IDLE→RUN: `start`=1 with `num_words`>0. Latch `base_addr` and `num_words`; clear the issue offset `k`.
- IDLE with `start`=1 and `num_words`=0: stay in IDLE, `busy` stays 0, `done` pulses the next cycle.
- Issue rule in RUN:
  - Offset `k` is issued when `k < avail_count` and `credit > 0`.
  - `credit = 2 - (buf_count + inflight) + pop`, where `pop = m_tvalid & m_tready`.
  - On issue: `ram_rd_addr = (base + k)`, wrapping to 0 after DEPTH-1 (explicit compare, not only power-of-two truncation). Set `inflight` for the next cycle and increment `k`.
- When no read is issued, `ram_rd_addr` holds its value. `ram_dout` in the following cycle is ignored.
- Each cycle with `inflight`=1, `ram_dout` is pushed into the 2-entry FIFO. Overflow is impossible by construction; flag it as an assertion.
- RUN→DRAIN: after offset `num_words-1` is issued.
- DRAIN→IDLE: on the handshake of the beat with `m_tlast`=1. `done`=1 and `busy`=0 in the next cycle.
- `m_tlast` marks the beat with offset `num_words-1`.
- Stream rules:
  - `m_tdata` and `m_tlast` stay stable while `m_tvalid`=1 and `m_tready`=0.
  - `m_tvalid` never drops without a handshake.
- `start` while `busy`=1 is ignored. Changing `base_addr` or `num_words` mid-job has no effect.
- `rst` mid-job aborts immediately:
  - State returns to IDLE.
  - FIFO and `inflight` are cleared and their data discarded.
  - No `done` pulse.

## Timing
- Reset values: `m_tvalid`=0, `m_tlast`=0, `m_tdata`=0, `busy`=0, `done`=0, `ram_rd_addr`=0; state IDLE.
- Latency:
  - `start` high in cycle 0 → `busy`=1 and first `ram_rd_addr` in cycle 1 (if `avail_count`≥1).
  - `ram_dout` is valid in cycle 2; `m_tvalid`=1 in cycle 3.
- Throughput: 1 beat/cycle with `m_tready`=1 and `avail_count` ahead of `k`. No bubbles at wrap-around.
- Writer coupling: `avail_count` must increment no earlier than the cycle after the RAM write edge. The RAM returns old data on a same-address, same-edge read/write.
- Minimum job (`num_words`=1, `m_tready`=1): beat in cycle 3, `done` in cycle 4, `busy`=0 in cycle 4.
- A new `start` is accepted in the same cycle `done` is high.

## Test plan
- Basic: RAM[i]=i, `base_addr`=0, `num_words`=8, `avail_count`=64, `m_tready`=1 → beats 0..7 in cycles 3..10, `m_tlast` on 7, `done` in cycle 11.
- Wrap: DEPTH=6, `base_addr`=4, `num_words`=5 → addresses 4,5,0,1,2 issued back-to-back, data in the same order.
- Backpressure: toggle `m_tready` pseudo-randomly over a 32-word job → every word delivered exactly once in order, data stable while stalled, never more than 2 buffered plus 1 in flight.
- Concurrent writer: `avail_count` starts at 0 and increments every 3 cycles → reads wait on `avail_count`, no stale data, final order 0..N-1.
- Edge commands: `num_words`=0 → `done` in cycle 1 with `busy`=0. `start` while busy → ignored.
- Reset mid-job after 3 beats → next cycle all outputs at reset values, no `done`. A new job of 4 words then completes correctly.

Source files
------------

// File: rtl/ram_stream_out_if.sv
// Valid/ready output stream carrying result-RAM words to the downstream consumer.
interface ram_stream_out_if #(
  parameter int DATA_WIDTH = 4096
);
  logic [DATA_WIDTH-1:0] m_tdata;
  logic                  m_tvalid;
  logic                  m_tlast;
  logic                  m_tready;

  modport master (output m_tdata, output m_tvalid, output m_tlast, input m_tready);
  modport slave  (input m_tdata, input m_tvalid, input m_tlast, output m_tready);
endinterface

// File: rtl/ram_stream_out.sv
// Read-side streaming engine for the Multi-MAC result RAM: walks num_words addresses
// from base_addr with wrap-around, reading only words the writer has committed.
module ram_stream_out #(
  parameter int  DATA_WIDTH = 4096,
  parameter int  DEPTH      = 64,
  localparam int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [AW-1:0]         base_addr,
  input  logic [AW:0]           num_words,
  input  logic [AW:0]           avail_count,
  output logic [AW-1:0]         ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  ram_stream_out_if.master      strm,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nxt;

  logic [AW:0]           k;
  logic [AW:0]           num_q;
  logic [AW-1:0]         cur_addr;
  logic [AW-1:0]         addr_hold;
  logic                  vld_p1;
  logic                  last_p1;
  logic [DATA_WIDTH-1:0] buf_data [2];
  logic [1:0]            buf_last;
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            buf_count;
  logic                  pop;
  logic                  push;
  logic                  issue;
  logic                  issue_last;
  logic                  credit_ok;
  logic [2:0]            occ;

  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] a);
    if (a == AW'(DEPTH - 1)) return '0;
    return a + AW'(1);
  endfunction

  assign strm.m_tvalid = (buf_count != 2'd0);
  assign strm.m_tdata  = strm.m_tvalid ? buf_data[rd_ptr] : '0;
  assign strm.m_tlast  = strm.m_tvalid & buf_last[rd_ptr];
  assign busy          = (state != IDLE);

  // Stage p0: issue decision; a read is only launched if its word is guaranteed a buffer slot.
  always_comb begin
    pop         = strm.m_tvalid & strm.m_tready;
    push        = vld_p1;
    occ         = {1'b0, buf_count} + {2'b00, vld_p1};
    credit_ok   = occ < (3'd2 + {2'b00, pop});
    issue       = (state == RUN) && (k < avail_count) && credit_ok;
    issue_last  = issue && (k == num_q - (AW+1)'(1));
    ram_rd_addr = issue ? cur_addr : addr_hold;
    state_nxt   = state;
    case (state)
      IDLE:    if (start && (num_words != '0)) state_nxt = RUN;
      RUN:     if (issue_last) state_nxt = DRAIN;
      DRAIN:   if (pop && strm.m_tlast) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr_hold <= '0;
      vld_p1    <= 1'b0;
      buf_count <= 2'd0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      addr_hold <= ram_rd_addr;
      vld_p1    <= issue;
      done      <= ((state == IDLE) && start && (num_words == '0)) ||
                   ((state == DRAIN) && pop && strm.m_tlast);
      if (push) wr_ptr <= ~wr_ptr;
      if (pop) rd_ptr <= ~rd_ptr;
      buf_count <= buf_count + {1'b0, push} - {1'b0, pop};
      if (push && !pop) assert (buf_count != 2'd2);
    end
  end

  // Stage p1: RAM word arrives and lands in the 2-entry output buffer.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && start) begin
      k        <= '0;
      num_q    <= num_words;
      cur_addr <= base_addr;
    end else if (issue) begin
      k        <= k + (AW+1)'(1);
      cur_addr <= wrap_inc(cur_addr);
    end
    last_p1 <= issue_last;
    if (push) begin
      buf_data[wr_ptr] <= ram_dout;
      buf_last[wr_ptr] <= last_p1;
    end
  end

endmodule

// File: tb/tb_ram_stream_out.sv
// Scoreboard bench for ram_stream_out: each job queues its expected beats, and a
// negedge monitor pops and compares every handshake against the queue.
`timescale 1ns/1ps
module tb_ram_stream_out;
  localparam int DW    = 32;
  localparam int DEPTH = 40;
  localparam int AW    = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   num_words;
  logic [AW:0]   avail_count;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_dout;
  logic          busy;
  logic          done;

  ram_stream_out_if #(.DATA_WIDTH(DW)) strm();

  ram_stream_out #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .num_words(num_words), .avail_count(avail_count), .ram_rd_addr(ram_rd_addr),
    .ram_dout(ram_dout), .strm(strm), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Synchronous RAM with read-old-data behaviour on a same-edge collision.
  logic          we;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd;
  logic [DW-1:0] ram   [DEPTH];
  logic [DW-1:0] model [DEPTH];
  always @(posedge clk) begin
    if (we) ram[wa] <= wd;
    ram_dout <= ram[ram_rd_addr];
  end

  typedef struct packed {logic [DW-1:0] d; logic l;} beat_t;
  beat_t exp_q[$];

  int checks = 0, failures = 0;
  int cyc = 0, t0 = 0, dc = 0, n0 = 0;
  int beats_seen = 0, first_cyc = -1, last_cyc = -1, done_cnt = 0;
  bit bp_en = 1'b0;
  logic [15:0] lfsr;
  logic stall_prev = 1'b0;
  logic [DW-1:0] prev_d;
  logic prev_l;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic write_word(input int a, input logic [DW-1:0] d);
    we = 1'b1; wa = AW'(a); wd = d; model[a] = d;
  endtask

  task automatic start_job(input int b, input int n, input bit do_push);
    if (do_push)
      for (int i = 0; i < n; i++) begin
        beat_t e;
        e.d = model[(b + i) % DEPTH];
        e.l = (i == n - 1);
        exp_q.push_back(e);
      end
    beats_seen = 0; first_cyc = -1; last_cyc = -1;
    base_addr = AW'(b); num_words = (AW+1)'(n); start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output int dcyc);
    dcyc = -1;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin dcyc = cyc; break; end
    end
    if (dcyc < 0) begin
      checks++; failures++;
      $display("FAIL done_timeout: actual=no done required=done within %0d cycles", max_cyc);
    end
  endtask

  // Consumer ready: constant 1, or a pseudo-random pattern while backpressure is enabled.
  initial begin
    lfsr = 16'hACE1;
    strm.m_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      strm.m_tready = bp_en ? lfsr[0] : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst !== 1'b0) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid_held", strm.m_tvalid, 1);
        check("stall_data_held", strm.m_tdata, prev_d);
        check("stall_last_held", strm.m_tlast, prev_l);
      end
      if (strm.m_tvalid && strm.m_tready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_beat: actual=0x%0h required=no beat", strm.m_tdata);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat_data", strm.m_tdata, e.d);
          check("beat_last", strm.m_tlast, e.l);
        end
        if (beats_seen == 0) first_cyc = cyc;
        if (strm.m_tlast) last_cyc = cyc;
        beats_seen++;
      end
      if (done) done_cnt++;
      stall_prev = strm.m_tvalid && !strm.m_tready;
      prev_d = strm.m_tdata;
      prev_l = strm.m_tlast;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; num_words = '0; avail_count = '0;
    we = 1'b0; wa = '0; wd = '0;
    for (int i = 0; i < DEPTH; i++) begin
      @(posedge clk); #1;
      write_word(i, 32'hC0DE_0000 | DW'(i));
    end
    @(posedge clk); #1; we = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("rst_tvalid", strm.m_tvalid, 0);
    check("rst_tlast", strm.m_tlast, 0);
    check("rst_tdata", strm.m_tdata, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_addr", ram_rd_addr, 0);

    // Basic 8-word job.
    avail_count = (AW+1)'(DEPTH);
    @(posedge clk); #1;
    start_job(0, 8, 1);
    @(negedge clk);
    check("basic_busy_c1", busy, 1);
    check("basic_addr_c1", ram_rd_addr, 0);
    wait_done(40, dc);
    check("basic_first_beat_cyc", first_cyc, t0 + 3);
    check("basic_last_beat_cyc", last_cyc, t0 + 10);
    check("basic_done_cyc", dc, t0 + 11);
    check("basic_busy_at_done", busy, 0);
    check("basic_queue_empty", exp_q.size(), 0);

    // Single-word job started in the same cycle as the previous done.
    start_job(39, 1, 1);
    @(negedge clk);
    check("min_busy_c1", busy, 1);
    check("min_addr_c1", ram_rd_addr, 39);
    wait_done(20, dc);
    check("min_beat_cyc", first_cyc, t0 + 3);
    check("min_done_cyc", dc, t0 + 4);
    check("min_busy_at_done", busy, 0);

    // Wrap at a non-power-of-two depth: 37,38,39,0,1,2 back to back.
    @(posedge clk); #1;
    start_job(37, 6, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("wrap_addr", ram_rd_addr, (37 + i) % DEPTH);
    end
    wait_done(30, dc);
    check("wrap_last_beat_cyc", last_cyc, t0 + 8);
    check("wrap_done_cyc", dc, t0 + 9);

    // Zero-length command.
    @(posedge clk); #1;
    n0 = done_cnt;
    start_job(5, 0, 1);
    @(negedge clk);
    check("zero_done_c1", done, 1);
    check("zero_busy_c1", busy, 0);
    @(negedge clk);
    check("zero_done_c2", done, 0);
    check("zero_done_count", done_cnt - n0, 1);

    // 32-word job under pseudo-random backpressure, wrapping past address 39.
    @(posedge clk); #1;
    bp_en = 1'b1;
    start_job(10, 32, 1);
    wait_done(600, dc);
    bp_en = 1'b0;
    check("bp_beats", beats_seen, 32);
    check("bp_queue_empty", exp_q.size(), 0);

    // Concurrent writer: one new word committed every 3 cycles.
    @(posedge clk); #1;
    avail_count = '0;
    for (int i = 0; i < 6; i++) begin
      beat_t e;
      e.d = 32'h5A5A_0000 | DW'(i);
      e.l = (i == 5);
      exp_q.push_back(e);
    end
    start_job(5, 6, 0);
    fork
      for (int i = 0; i < 6; i++) begin
        write_word(5 + i, 32'h5A5A_0000 | DW'(i));
        @(posedge clk); #1;
        we = 1'b0;
        avail_count = avail_count + (AW+1)'(1);
        @(posedge clk); #1;
        @(posedge clk); #1;
      end
      wait_done(200, dc);
    join
    check("wr_beats", beats_seen, 6);
    check("wr_queue_empty", exp_q.size(), 0);
    check("wr_last_after_commit", last_cyc > t0 + 16, 1);
    avail_count = (AW+1)'(DEPTH);

    // start while busy must be ignored.
    @(posedge clk); #1;
    n0 = done_cnt;
    start_job(0, 4, 1);
    base_addr = AW'(20); num_words = (AW+1)'(3); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(30, dc);
    check("busy_start_done_cyc", dc, t0 + 7);
    repeat (10) @(negedge clk);
    check("busy_start_done_count", done_cnt - n0, 1);
    check("busy_start_queue_empty", exp_q.size(), 0);
    check("busy_start_idle", busy, 0);

    // Reset in the middle of a 10-word job after 3 beats.
    @(posedge clk); #1;
    start_job(0, 10, 1);
    for (int i = 0; i < 40; i++) begin
      if (beats_seen >= 3) break;
      @(posedge clk); #1;
    end
    check("rst_mid_reached_3_beats", beats_seen >= 3, 1);
    n0 = done_cnt;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("rst_mid_tvalid", strm.m_tvalid, 0);
    check("rst_mid_tlast", strm.m_tlast, 0);
    check("rst_mid_tdata", strm.m_tdata, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_rd_addr", ram_rd_addr, 0);
    repeat (12) @(negedge clk);
    check("rst_mid_no_done", done_cnt - n0, 0);

    // Fresh 4-word job after the abort.
    @(posedge clk); #1;
    start_job(2, 4, 1);
    wait_done(30, dc);
    check("post_rst_first_beat_cyc", first_cyc, t0 + 3);
    check("post_rst_done_cyc", dc, t0 + 7);
    check("post_rst_beats", beats_seen, 4);
    check("post_rst_queue_empty", exp_q.size(), 0);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
